// File: rtl/mem_stall_responder_pkg.sv
// Shared definitions for the multi-cycle memory responder: FSM state and
// operation encodings plus the request-legality helpers.
package mem_stall_responder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_BUSY = 2'b01,
        MS_DONE = 2'b10
    } ms_state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // A request is illegal when both strobes are up, or any strobe targets an odd byte.
    function automatic logic req_illegal(input logic rd, input logic wr, input logic a0);
        return (rd & wr) | ((rd | wr) & a0);
    endfunction

    // A request is serviceable when exactly one strobe is up on an even byte.
    function automatic logic req_legal(input logic rd, input logic wr, input logic a0);
        return (rd ^ wr) & ~a0;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with write enable and a registered read
// port. The read register only loads on a read, so it holds the last read
// word across writes and idle cycles. Storage itself is never reset.
module mem_word_array
    import mem_stall_responder_pkg::*;
#(
    parameter int WORD_ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   we,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0]      wdata,
    output logic [WORD_W-1:0]      rdata
);

    logic [WORD_W-1:0] mem [0:(1 << WORD_ADDR_W)-1];

    // Write port: commit the word on an enabled write.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: reset clears only the visible output, not the storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stall_responder.sv
// Responder end of the core's memory interface. Accepts one read or write,
// holds Stall while the access is in flight, and pulses Done when it
// completes LATENCY cycles after acceptance. Illegal requests pulse err.
module mem_stall_responder
    import mem_stall_responder_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       DataIn,
    output logic [15:0]       DataOut,
    output logic              Stall,
    output logic              Done,
    output logic              err
);

    localparam int WA_W  = ADDR_W - 1;
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ms_state_e         state;
    ms_state_e         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              op_q;
    logic [WA_W-1:0]   waddr_q;
    logic [15:0]       wdata_q;

    logic              accepting;
    logic              req_ok;
    logic              req_bad;

    logic              mem_en;
    logic              mem_we;
    logic [WA_W-1:0]   mem_addr;
    logic [15:0]       mem_wdata;

    assign accepting = (state == MS_IDLE) || (state == MS_DONE);
    assign req_ok    = accepting && req_legal(Rd, Wr, Addr[0]);
    assign req_bad   = accepting && req_illegal(Rd, Wr, Addr[0]);

    // Next state, counter and the RAM strobe for the completing edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        case (state)
            MS_BUSY: begin
                // Inputs are ignored here; only the counter advances.
                if (cnt <= CNT_ONE) begin
                    state_nxt = MS_DONE;
                    mem_en    = 1'b1;
                    mem_we    = (op_q == OP_WR);
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            MS_IDLE, MS_DONE: begin
                if (req_ok) begin
                    cnt_nxt = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_nxt = MS_BUSY;
                    end else begin
                        // Single-cycle latency completes at the accepting edge,
                        // so the RAM is driven straight from the request.
                        state_nxt = MS_DONE;
                        mem_en    = 1'b1;
                        mem_we    = Wr;
                        mem_addr  = Addr[ADDR_W-1:1];
                        mem_wdata = DataIn;
                    end
                end else begin
                    state_nxt = MS_IDLE;
                end
            end
            default: begin
                state_nxt = MS_IDLE;
            end
        endcase
    end

    // Control state and registered handshake outputs; reset aborts any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MS_IDLE;
            cnt   <= '0;
            Stall <= 1'b0;
            Done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Stall <= (state_nxt == MS_BUSY);
            Done  <= (state_nxt == MS_DONE);
            err   <= req_bad;
        end
    end

    // Request latches: capture op, word address and write data on acceptance.
    always_ff @(posedge clk) begin
        if (req_ok) begin
            op_q    <= Wr ? OP_WR : OP_RD;
            waddr_q <= Addr[ADDR_W-1:1];
            wdata_q <= DataIn;
        end
    end

    mem_word_array #(
        .WORD_ADDR_W(WA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (DataOut)
    );

endmodule
